// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------------+
// | div_pkg: shared state encoding, saturation constant and result record for   |
// | the 16x8 divide stage.                                                      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package div_pkg;

    localparam int          STATE_W = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_EVAL = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;

    localparam logic [7:0]  SAT_VAL = 8'hFF;

    typedef struct packed {
        logic [7:0] quot;
        logic [7:0] rem;
        logic       dbz;
        logic       ovf;
    } result_t;

    // Divide-by-zero keeps the low dividend byte as remainder; overflow saturates both.
    function automatic result_t special_result(input logic [7:0] dividend_lo,
                                               input logic       is_dbz);
        result_t res;
        res.quot = SAT_VAL;
        res.rem  = is_dbz ? dividend_lo : SAT_VAL;
        res.dbz  = is_dbz;
        res.ovf  = ~is_dbz;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div16x8_stage_if.sv
// +----------------------------------------------------------------------------+
// | div16x8_stage_if: request/result handshake bundle of the divide stage.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface div16x8_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dividend;
    logic [7:0]  in_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_quot;
    logic [7:0]  out_rem;
    logic        out_dbz;
    logic        out_ovf;

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
    );

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quot, out_rem, out_dbz, out_ovf
    );

endinterface

`default_nettype wire

// File: rtl/div16x8_stage_array.sv
// +----------------------------------------------------------------------------+
// | array: 16x8 restoring array divider core, one subtract row per quotient bit.|
// | Result is exact only when dividend[15:8] < divisor.                         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module array (
    input  wire logic [15:0] dividend,
    input  wire logic [7:0]  divisor,
    input  wire logic        bin,
    output logic      [7:0]  quot,
    output logic      [7:0]  rem
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            logic [7:0] w_rem_in;
            logic [7:0] w_rem_out;
            logic [8:0] w_trial;
            logic [7:0] w_sub;
            logic       w_borrow;
            logic       w_q;

            if (gi == 0) begin : g_first
                assign w_rem_in = dividend[15:8];
            end else begin : g_next
                assign w_rem_in = g_row[gi-1].w_rem_out;
            end

            // Partial remainder stays below the divisor, so a non-borrowing difference fits 8 bits.
            assign w_trial   = {w_rem_in, dividend[7-gi]};
            assign w_borrow  = w_trial < ({1'b0, divisor} + {8'd0, bin});
            assign w_sub     = 8'(w_trial - {1'b0, divisor} - {8'd0, bin});
            assign w_q       = ~w_borrow;
            assign w_rem_out = w_borrow ? w_trial[7:0] : w_sub;
        end
    endgenerate

    assign quot = {g_row[0].w_q, g_row[1].w_q, g_row[2].w_q, g_row[3].w_q,
                   g_row[4].w_q, g_row[5].w_q, g_row[6].w_q, g_row[7].w_q};
    assign rem  = g_row[7].w_rem_out;

endmodule

`default_nettype wire

// File: rtl/div16x8_stage.sv
// +----------------------------------------------------------------------------+
// | div16x8_stage: handshaked 16/8 unsigned divide, fixed 2-cycle latency, with |
// | divide-by-zero / overflow flags and a saturating error-event counter.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module div16x8_stage
    import div_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    div16x8_stage_if.slave            bus,
    input  wire logic                 err_clr,
    output logic      [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next_state;
    logic [15:0]          r_dividend;
    logic [7:0]           r_divisor;
    logic [7:0]           w_core_quot;
    logic [7:0]           w_core_rem;
    logic                 w_dbz;
    logic                 w_ovf;
    logic                 w_err;
    result_t              w_result;
    result_t              r_result;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_next_state = ST_EVAL;
            ST_EVAL:                    w_next_state = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE) && !rst;
        bus.out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
        end else if ((r_state == ST_IDLE) && bus.in_valid) begin
            r_dividend <= bus.in_dividend;
            r_divisor  <= bus.in_divisor;
        end
    end

    array u_array (
        .dividend (r_dividend),
        .divisor  (r_divisor),
        .bin      (1'b0),
        .quot     (w_core_quot),
        .rem      (w_core_rem)
    );

    // The core is only exact when the quotient fits 8 bits; special cases bypass it.
    assign w_dbz = (r_divisor == 8'd0);
    assign w_ovf = !w_dbz && (r_dividend[15:8] >= r_divisor);
    assign w_err = w_dbz || w_ovf;

    always_comb begin
        w_result.quot = w_core_quot;
        w_result.rem  = w_core_rem;
        w_result.dbz  = 1'b0;
        w_result.ovf  = 1'b0;
        if (w_err) begin
            w_result = special_result(r_dividend[7:0], w_dbz);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (r_state == ST_EVAL) begin
            r_result <= w_result;
        end
    end

    assign bus.out_quot = r_result.quot;
    assign bus.out_rem  = r_result.rem;
    assign bus.out_dbz  = r_result.dbz;
    assign bus.out_ovf  = r_result.ovf;

    // A clear coinciding with an error event leaves exactly that one event counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_EVAL) && w_err) begin
            if (err_clr) begin
                r_err_cnt <= {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else if (r_err_cnt != CNT_MAX) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

`default_nettype wire
